// File: rtl/arith_sequencer_pkg.sv
// Shared encodings for the arithmetic-unit micro-sequencer: op codes, FSM states, sizes.
package arith_seq_pkg;

  localparam int WIDTH     = 30;
  localparam int MUL_STEPS = 30;
  localparam int CNT_W     = 5;

  // 3'b110 and 3'b111 are NOP and intentionally left unnamed
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_MUL = 3'b011,
    OP_CMP = 3'b100,
    OP_SHR = 3'b101
  } op_e;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_MOVB,
    ST_NOTB,
    ST_SUM,
    ST_WB,
    ST_FIN,
    ST_ANDS,
    ST_CLRB,
    ST_MADD,
    ST_MSHF,
    ST_SHF
  } state_e;

endpackage

// File: rtl/arith_sequencer_if.sv
// Instruction-stage / AU side of the sequencer: request, status and AU strobe bundle.
interface arith_seq_if;

  logic                           start;
  logic [2:0]                     op;
  logic [arith_seq_pkg::CNT_W-1:0] shamt;
  logic                           busy;
  logic                           done;
  logic                           flag;
  logic                           reg_b_0;
  logic                           reg_c_30;
  logic                           do_clear_b;
  logic                           do_not_b;
  logic                           do_sum;
  logic                           do_and;
  logic                           do_right_shift_bc;
  logic                           do_move_c_to_b;
  logic                           do_move_b_to_c;

  modport master (
    output start, op, shamt, reg_b_0, reg_c_30,
    input  busy, done, flag, do_clear_b, do_not_b, do_sum, do_and,
           do_right_shift_bc, do_move_c_to_b, do_move_b_to_c
  );

  modport slave (
    input  start, op, shamt, reg_b_0, reg_c_30,
    output busy, done, flag, do_clear_b, do_not_b, do_sum, do_and,
           do_right_shift_bc, do_move_c_to_b, do_move_b_to_c
  );

endinterface

// File: rtl/arith_sequencer_au_step_counter.sv
// Loadable down-counter with zero detect; paces the MUL step loop and the SHR shift loop.
module au_step_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/arith_sequencer.sv
// Micro-sequencer issuing AU strobe sequences for ADD/SUB/CMP/AND/MUL/SHR; result lands in C.
module arith_sequencer (
  input  logic        clk,
  input  logic        resetn,
  arith_seq_if.slave  bus
);
  import arith_seq_pkg::*;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       flag_q, flag_d;
  logic       cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  au_step_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .resetn     (resetn),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d               = state_q;
    op_d                  = op_q;
    flag_d                = flag_q;
    cnt_load              = 1'b0;
    cnt_dec               = 1'b0;
    cnt_load_val          = '0;
    bus.do_clear_b        = 1'b0;
    bus.do_not_b          = 1'b0;
    bus.do_sum            = 1'b0;
    bus.do_and            = 1'b0;
    bus.do_right_shift_bc = 1'b0;
    bus.do_move_c_to_b    = 1'b0;
    bus.do_move_b_to_c    = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        op_d   = bus.op;
        flag_d = 1'b0;
        case (bus.op)
          OP_ADD, OP_SUB, OP_CMP: state_d = ST_MOVB;
          OP_AND:                 state_d = ST_ANDS;
          OP_MUL: begin
            state_d      = ST_CLRB;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(MUL_STEPS - 1);
          end
          OP_SHR: begin
            state_d      = (bus.shamt == '0) ? ST_FIN : ST_SHF;
            cnt_load     = 1'b1;
            cnt_load_val = bus.shamt - CNT_W'(1);
          end
          default:                state_d = ST_FIN;
        endcase
      end
      ST_MOVB: begin
        bus.do_move_c_to_b = 1'b1;
        state_d = (op_q == OP_ADD) ? ST_SUM : ST_NOTB;
      end
      ST_NOTB: begin
        bus.do_not_b = 1'b1;
        state_d      = ST_SUM;
      end
      ST_SUM: begin
        bus.do_sum = 1'b1;
        state_d    = ST_WB;
      end
      // CMP keeps C intact; the borrow is the inverted carry out of A + ~Y + 1
      ST_WB: begin
        bus.do_move_b_to_c = (op_q != OP_CMP);
        if (op_q == OP_ADD)
          flag_d = bus.reg_b_0;
        else if (op_q == OP_SUB || op_q == OP_CMP)
          flag_d = ~bus.reg_b_0;
        state_d = ST_FIN;
      end
      ST_ANDS: begin
        bus.do_and = 1'b1;
        state_d    = ST_FIN;
      end
      ST_CLRB: begin
        bus.do_clear_b = 1'b1;
        state_d        = ST_MADD;
      end
      ST_MADD: begin
        bus.do_sum = bus.reg_c_30;
        state_d    = ST_MSHF;
      end
      ST_MSHF: begin
        bus.do_right_shift_bc = 1'b1;
        cnt_dec = ~cnt_zero;
        state_d = cnt_zero ? ST_WB : ST_MADD;
      end
      ST_SHF: begin
        bus.do_right_shift_bc = 1'b1;
        cnt_dec = ~cnt_zero;
        state_d = cnt_zero ? ST_FIN : ST_SHF;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flag_q  <= flag_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_FIN);
  assign bus.flag = flag_q;

endmodule
